// File: rtl/hyperram_lb_regs.sv
// Local-bus register responder sequencing single-word HyperRAM transactions.
// Optional build macro: HYPERRAM_LB_AUTOINC_EN (ADDR post-increment on successful completion).
module hyperram_lb_regs #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lb_wr,
    input  logic        lb_rd,
    input  logic [31:0] lb_addr,
    input  logic [31:0] lb_wr_d,
    output logic [31:0] lb_rd_d,
    output logic        lb_rd_rdy,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    localparam logic [7:0] A_ADDR = 8'h10;
    localparam logic [7:0] A_DATA = 8'h14;
    localparam logic [7:0] A_STS  = 8'h18;
    localparam logic [7:0] A_CMD  = 8'h1c;

    localparam logic [DW-1:0] CMD_WR = DW'(1);
    localparam logic [DW-1:0] CMD_RD = DW'(4);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:1]    sts_q, sts_d;
    logic [DW-1:0] lb_rd_d_q, lb_rd_d_d;
    logic          lb_rd_rdy_q, lb_rd_rdy_d;
    logic          busy_q, busy_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          wr_addr, wr_data, wr_sts, wr_cmd, in_cmd;
    logic          done;
    logic [3:1]    sts_set, sts_clr;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^lb_addr[31:8];

    // Register decode, status bookkeeping and command sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        lb_rd_d_d   = lb_rd_d_q;
        lb_rd_rdy_d = lb_rd;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        sts_set     = 3'b000;
        sts_clr     = 3'b000;
        done        = 1'b0;

        in_cmd  = (state_q != ST_IDLE);
        wr_addr = lb_wr && (lb_addr[7:0] == A_ADDR);
        wr_data = lb_wr && (lb_addr[7:0] == A_DATA);
        wr_sts  = lb_wr && (lb_addr[7:0] == A_STS);
        wr_cmd  = lb_wr && (lb_addr[7:0] == A_CMD);

        if (in_cmd && (wr_addr || wr_data || wr_cmd)) begin
            sts_set[3] = 1'b1;
        end
        if (!in_cmd && wr_addr) addr_d  = lb_wr_d;
        if (!in_cmd && wr_data) wdata_d = lb_wr_d;
        if (wr_sts) sts_clr = lb_wr_d[3:1];

        // Reads see pre-write register values
        if (lb_rd) begin
            case (lb_addr[7:0])
                A_ADDR:  lb_rd_d_d = addr_q;
                A_DATA:  lb_rd_d_d = rdata_q;
                A_STS:   lb_rd_d_d = {28'd0, sts_q, busy_q};
                default: lb_rd_d_d = '0;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_cmd) begin
                    if (lb_wr_d == CMD_WR || lb_wr_d == CMD_RD) begin
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (lb_wr_d == CMD_WR);
                        mem_addr_d  = addr_q;
                        mem_wdata_d = wdata_q;
                    end else begin
                        sts_set[2] = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    if (mem_we_q) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    sts_set[1] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RDATA: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    sts_set[1] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

`ifdef HYPERRAM_LB_AUTOINC_EN
        if (done) addr_d = addr_q + DW'(1);
`endif

        busy_d = (state_d != ST_IDLE);
        sts_d  = (sts_q & ~sts_clr) | sts_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sts_q       <= '0;
            lb_rd_d_q   <= '0;
            lb_rd_rdy_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sts_q       <= sts_d;
            lb_rd_d_q   <= lb_rd_d_d;
            lb_rd_rdy_q <= lb_rd_rdy_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign lb_rd_d   = lb_rd_d_q;
    assign lb_rd_rdy = lb_rd_rdy_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_hyperram_lb_regs.sv
// Directed self-checking bench for hyperram_lb_regs (TIMEOUT = 16).
module tb_hyperram_lb_regs;

`ifdef HYPERRAM_LB_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lb_wr = 1'b0, lb_rd = 1'b0;
    logic [31:0] lb_addr = '0, lb_wr_d = '0;
    logic [31:0] lb_rd_d;
    logic        lb_rd_rdy, busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    hyperram_lb_regs #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
        .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // One clock: inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lb_write(input logic [7:0] a, input logic [31:0] d);
        lb_wr = 1'b1; lb_addr = {24'd0, a}; lb_wr_d = d;
        step();
        lb_wr = 1'b0;
    endtask

    task automatic lb_read(input logic [7:0] a, output logic [31:0] d, output logic rdy);
        lb_rd = 1'b1; lb_addr = {24'd0, a};
        step();
        lb_rd = 1'b0;
        d = lb_rd_d; rdy = lb_rd_rdy;
    endtask

    task automatic ack_pulse();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic rvalid_pulse(input logic [31:0] d);
        mem_rvalid = 1'b1; mem_rdata = d;
        step();
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic r;
        reset = 1'b1; step(); step(); reset = 1'b0;
        n_tests++;
        if ({lb_rd_rdy, busy, mem_req, mem_we} !== 4'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || lb_rd_d !== 32'd0) begin
            n_fail++; $display("FAIL reset_outputs rdy=%b busy=%b req=%b we=%b addr=%h wdata=%h rd_d=%h want all 0", lb_rd_rdy, busy, mem_req, mem_we, mem_addr, mem_wdata, lb_rd_d);
        end
        lb_read(8'h18, d, r);
        n_tests++;
        if (r !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL reset_status rdy=%b d=%h want 1/0", r, d); end
    endtask

    task automatic test_write();
        int hi = 0;
        lb_write(8'h10, 32'h100);
        lb_write(8'h14, 32'hDEADBEEF);
        lb_write(8'h1c, 32'd1);
        n_tests++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_req req=%b busy=%b we=%b addr=%h wdata=%h want 1 1 1 100 deadbeef", mem_req, busy, mem_we, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 4; i++) begin step(); if (mem_req === 1'b1) hi++; end
        n_tests++;
        if (hi !== 4) begin n_fail++; $display("FAIL write_req_hold got %0d want 4", hi); end
        ack_pulse();
        n_tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL write_done req=%b busy=%b want 0 0", mem_req, busy); end
    endtask

    task automatic test_read();
        logic [31:0] d; logic r;
        lb_write(8'h10, 32'h100);
        lb_write(8'h1c, 32'd4);
        n_tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL read_req req=%b we=%b addr=%h want 1 0 100", mem_req, mem_we, mem_addr);
        end
        step(); step();
        ack_pulse();
        n_tests++;
        if (mem_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL read_ack req=%b busy=%b want 0 1", mem_req, busy); end
        for (int i = 0; i < 6; i++) step();
        rvalid_pulse(32'h12345678);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL read_done busy=%b want 0", busy); end
        lb_read(8'h14, d, r);
        n_tests++;
        if (r !== 1'b1 || d !== 32'h12345678) begin n_fail++; $display("FAIL read_data rdy=%b d=%h want 1 12345678", r, d); end
        step();
        n_tests++;
        if (lb_rd_rdy !== 1'b0 || lb_rd_d !== 32'h12345678) begin n_fail++; $display("FAIL rd_hold rdy=%b d=%h want 0 12345678", lb_rd_rdy, lb_rd_d); end
        lb_read(8'h18, d, r);
        n_tests++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL read_status got %h want 0", d); end
        // Simultaneous write and read of ADDR returns the old value
        lb_wr = 1'b1; lb_rd = 1'b1; lb_addr = 32'h10; lb_wr_d = 32'h200;
        step();
        lb_wr = 1'b0; lb_rd = 1'b0;
        n_tests++;
        if (lb_rd_d !== (AI ? 32'h101 : 32'h100)) begin n_fail++; $display("FAIL wr_rd_same got %h want %h", lb_rd_d, AI ? 32'h101 : 32'h100); end
        lb_read(8'h10, d, r);
        n_tests++;
        if (d !== 32'h200) begin n_fail++; $display("FAIL wr_rd_after got %h want 200", d); end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic r;
        int hi = 0;
        lb_write(8'h1c, 32'd1);
        if (busy === 1'b1) hi++;
        for (int i = 0; i < 15; i++) begin step(); if (busy === 1'b1) hi++; end
        step();
        n_tests++;
        if (hi !== 16 || busy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL timeout_len busy_cycles=%0d busy=%b req=%b want 16 0 0", hi, busy, mem_req);
        end
        lb_read(8'h18, d, r);
        n_tests++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL timeout_status got %h want 2", d); end
        lb_read(8'h10, d, r);
        n_tests++;
        if (d !== 32'h200) begin n_fail++; $display("FAIL timeout_addr got %h want 200", d); end
        lb_write(8'h18, 32'h2);
        lb_read(8'h18, d, r);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL timeout_clear got %h want 0", d); end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic r;
        lb_write(8'h10, 32'h300);
        lb_write(8'h1c, 32'd4);
        lb_write(8'h10, 32'h55);
        lb_write(8'h1c, 32'd1);
        lb_read(8'h18, d, r);
        n_tests++;
        if (d !== 32'h9) begin n_fail++; $display("FAIL coll_status got %h want 9", d); end
        n_tests++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL coll_mem we=%b addr=%h want 0 300", mem_we, mem_addr); end
        ack_pulse();
        rvalid_pulse(32'hCAFEF00D);
        lb_read(8'h10, d, r);
        n_tests++;
        if (d !== (AI ? 32'h301 : 32'h300)) begin n_fail++; $display("FAIL coll_addr got %h want %h", d, AI ? 32'h301 : 32'h300); end
        lb_write(8'h18, 32'h8);
        lb_write(8'h1c, 32'd7);
        n_tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL badcmd_req req=%b busy=%b want 0 0", mem_req, busy); end
        lb_read(8'h18, d, r);
        n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL badcmd_status got %h want 4", d); end
        lb_write(8'h18, 32'hF);
        ack_pulse();
        rvalid_pulse(32'h1);
        lb_read(8'h14, d, r);
        n_tests++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || d !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL late_ack busy=%b req=%b rdata=%h want 0 0 cafef00d", busy, mem_req, d);
        end
        lb_read(8'h1c, d, r);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL cmd_read got %h want 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic r;
        lb_write(8'h10, 32'hFFFFFFFF);
        lb_write(8'h14, 32'h11);
        lb_write(8'h1c, 32'd1);
        ack_pulse();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_first busy=%b want 0", busy); end
        lb_write(8'h1c, 32'd1);
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== (AI ? 32'h0 : 32'hFFFFFFFF)) begin
            n_fail++; $display("FAIL b2b_second req=%b addr=%h want 1 %h", mem_req, mem_addr, AI ? 32'h0 : 32'hFFFFFFFF);
        end
        ack_pulse();
        lb_read(8'h10, d, r);
        n_tests++;
        if (d !== (AI ? 32'h1 : 32'hFFFFFFFF)) begin n_fail++; $display("FAIL b2b_addr got %h want %h", d, AI ? 32'h1 : 32'hFFFFFFFF); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic r;
        lb_write(8'h10, 32'h40);
        lb_write(8'h14, 32'h77);
        lb_write(8'h1c, 32'd4);
        ack_pulse();
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_rdata busy=%b want 1", busy); end
        reset = 1'b1; step(); reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset busy=%b req=%b addr=%h want 0 0 0", busy, mem_req, mem_addr);
        end
        rvalid_pulse(32'hABCD0123);
        lb_read(8'h10, d, r);
        n_tests++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL mid_addr got %h want 0", d); end
        lb_read(8'h14, d, r);
        n_tests++;
        if (d !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_rdata got %h busy=%b want 0 0", d, busy); end
        lb_read(8'h18, d, r);
        n_tests++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL mid_status got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
